// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write signals shared by program_loader and its host.
// The loader's behaviour can be configured with the PROGRAM_LOADER_CHECKSUM_EN macro.
interface program_loader_if;
   logic        start_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        mem_write_o;
   logic [31:0] mem_address_o;
   logic [31:0] mem_data_o;
   logic        cpu_reset_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;

   modport master (
      output start_i, byte_valid_i, byte_data_i,
      input  byte_ready_o, mem_write_o, mem_address_o, mem_data_o,
             cpu_reset_o, busy_o, done_o, error_o
   );

   modport slave (
      input  start_i, byte_valid_i, byte_data_i,
      output byte_ready_o, mem_write_o, mem_address_o, mem_data_o,
             cpu_reset_o, busy_o, done_o, error_o
   );
endinterface

// File: rtl/program_loader.sv
// Serial program loader: assembles big-endian words from a byte stream into program memory.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module program_loader #(
   parameter int unsigned MEMORY_DEPTH = 32,
   parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
   input  logic            clk,
   input  logic            reset,
   program_loader_if.slave bus
);

   localparam int unsigned IDX_W  = 8;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      COLLECT,
      WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE,
      ERROR
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    count;
   logic [IDX_W-1:0]    index;
   logic [1:0]          byte_cnt;
   logic [WORD_W-1:0]   word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]          sum;
`endif

   logic                byte_ready;
   logic                mem_write;
   logic [WORD_W-1:0]   mem_address;
   logic [WORD_W-1:0]   mem_data;
   logic                cpu_reset;
   logic                busy;
   logic                done;
   logic                error;
   logic                take_c;

   assign take_c = bus.byte_valid_i && byte_ready;

   // Next-state decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE, ERROR: begin
            if (bus.start_i) state_nxt = HEADER;
         end
         HEADER: begin
            if (take_c) begin
               if ((bus.byte_data_i == 8'd0) || (WORD_W'(bus.byte_data_i) > MEMORY_DEPTH))
                  state_nxt = ERROR;
               else
                  state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (take_c && (byte_cnt == 2'd3)) state_nxt = WRITE;
         end
         WRITE: begin
            if ((index + IDX_W'(1)) == count)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_nxt = CHECK;
`else
               state_nxt = DONE;
`endif
            else
               state_nxt = COLLECT;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (take_c) state_nxt = (bus.byte_data_i == sum) ? DONE : ERROR;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // State, flag and datapath registers; flags are decoded from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         byte_ready  <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= BASE_ADDRESS;
         mem_data    <= '0;
         cpu_reset   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         count       <= '0;
         index       <= '0;
         byte_cnt    <= '0;
         word        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum         <= '0;
`endif
      end else begin
         state      <= state_nxt;
         byte_ready <= (state_nxt == HEADER) || (state_nxt == COLLECT)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                       || (state_nxt == CHECK)
`endif
                       ;
         mem_write  <= (state_nxt == WRITE);
         cpu_reset  <= (state_nxt != DONE);
         done       <= (state_nxt == DONE);
         error      <= (state_nxt == ERROR);
         busy       <= (state_nxt == HEADER) || (state_nxt == COLLECT) || (state_nxt == WRITE)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                       || (state_nxt == CHECK)
`endif
                       ;

         unique case (state)
            HEADER: begin
               if (take_c) begin
                  count    <= bus.byte_data_i;
                  index    <= '0;
                  byte_cnt <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum      <= '0;
`endif
               end
            end
            COLLECT: begin
               if (take_c) begin
                  word     <= {word[23:0], bus.byte_data_i};
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum      <= sum + bus.byte_data_i;
`endif
                  if (byte_cnt == 2'd3) begin
                     mem_data    <= {word[23:0], bus.byte_data_i};
                     mem_address <= BASE_ADDRESS + (WORD_W'(index) << 2);
                  end
               end
            end
            WRITE: index <= index + IDX_W'(1);
            default: ;
         endcase
      end
   end

   assign bus.byte_ready_o  = byte_ready;
   assign bus.mem_write_o   = mem_write;
   assign bus.mem_address_o = mem_address;
   assign bus.mem_data_o    = mem_data;
   assign bus.cpu_reset_o   = cpu_reset;
   assign bus.busy_o        = busy;
   assign bus.done_o        = done;
   assign bus.error_o       = error;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a stream-level reference model.
// Honours PROGRAM_LOADER_CHECKSUM_EN in the same way as the design.
module tb_program_loader;

   localparam logic [31:0] BASE  = 32'h0040_0000;
   localparam int          DEPTH = 32;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   program_loader_if bus ();

   program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0]  stim[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   bit          exp_ok;
   int          exp_bytes;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Write monitor; a write cycle must never accept a byte
   always @(negedge clk) begin
      if (bus.mem_write_o === 1'b1) begin
         wr_addr.push_back(bus.mem_address_o);
         wr_data.push_back(bus.mem_data_o);
         wr_cyc = cyc;
         check("ready_in_write", 32'(bus.byte_ready_o), 32'd0);
      end
   end

   // Reference: what a stream should produce, from the stream format alone
   task automatic model();
      int n;
      logic [7:0] s;
      n = int'(stim[0]);
      s = 8'd0;
      exp_addr.delete();
      exp_data.delete();
      if (n == 0 || n > DEPTH) begin
         exp_ok = 1'b0;
         exp_bytes = 1;
         return;
      end
      for (int w = 0; w < n; w++) begin
         exp_addr.push_back(BASE + 32'(4 * w));
         exp_data.push_back({stim[1+4*w], stim[2+4*w], stim[3+4*w], stim[4+4*w]});
         for (int b = 1; b <= 4; b++) s = s + stim[4*w+b];
      end
      exp_bytes = 1 + 4 * n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      exp_bytes++;
      exp_ok = (stim[1+4*n] == s);
`else
      exp_ok = 1'b1;
`endif
   endtask

   task automatic build(input int n, input bit good_sum);
      logic [7:0] s;
      logic [7:0] b;
      s = 8'd0;
      stim.delete();
      stim.push_back(8'(n));
      for (int k = 0; k < 4 * n; k++) begin
         b = 8'($urandom);
         s = s + b;
         stim.push_back(b);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      stim.push_back(good_sum ? s : s + 8'd1);
`else
      if (good_sum) s = s + 8'd0;
`endif
   endtask

   task automatic run_session(input int valid_pct);
      int  i;
      int  budget;
      int  xfer_cyc;
      int  term_cyc;
      bit  term;
      bit  via_write;
      model();
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      check("start_ready", 32'(bus.byte_ready_o), 32'd1);
      check("start_busy",  32'(bus.busy_o),       32'd1);
      check("start_done",  32'(bus.done_o),       32'd0);
      check("start_cpurst", 32'(bus.cpu_reset_o), 32'd1);
      i = 0; budget = 0; term = 1'b0; xfer_cyc = cyc; term_cyc = cyc;
      while (!term && budget < 5000) begin
         if (bus.done_o || bus.error_o) begin
            term = 1'b1;
            term_cyc = cyc;
         end else begin
            if (i < stim.size() && (($urandom_range(99) < 32'(valid_pct)) || bus.mem_write_o)) begin
               bus.byte_valid_i = 1'b1;
               bus.byte_data_i  = stim[i];
            end else begin
               bus.byte_valid_i = 1'b0;
               bus.byte_data_i  = 8'($urandom);
            end
            bus.start_i = ($urandom_range(7) == 0);
            if (bus.byte_valid_i && bus.byte_ready_o) begin
               i++;
               xfer_cyc = cyc + 1;
            end
            @(negedge clk);
            budget++;
         end
      end
      bus.byte_valid_i = 1'b0;
      bus.start_i = 1'b0;
      check("term_reached", 32'(term), 32'd1);
      check("bytes_used", 32'(i), 32'(exp_bytes));
      check("done",   32'(bus.done_o),      32'(exp_ok));
      check("error",  32'(bus.error_o),     32'(!exp_ok));
      check("cpurst", 32'(bus.cpu_reset_o), 32'(!exp_ok));
      check("busy",   32'(bus.busy_o),      32'd0);
      check("wr_count", 32'(wr_addr.size()), 32'(exp_addr.size()));
      for (int j = 0; j < exp_addr.size() && j < wr_addr.size(); j++) begin
         check($sformatf("wr_addr[%0d]", j), wr_addr[j], exp_addr[j]);
         check($sformatf("wr_data[%0d]", j), wr_data[j], exp_data[j]);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      via_write = 1'b0;
`else
      via_write = exp_ok;
`endif
      check("release_lat", 32'(term_cyc), via_write ? 32'(wr_cyc + 1) : 32'(xfer_cyc));
   endtask

   initial begin
      int n;
      int fed;
      reset = 1'b1;
      bus.start_i = 1'b0;
      bus.byte_valid_i = 1'b0;
      bus.byte_data_i = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_ready",  32'(bus.byte_ready_o), 32'd0);
      check("rst_write",  32'(bus.mem_write_o),  32'd0);
      check("rst_addr",   bus.mem_address_o,     BASE);
      check("rst_data",   bus.mem_data_o,        32'd0);
      check("rst_cpurst", 32'(bus.cpu_reset_o),  32'd1);
      check("rst_busy",   32'(bus.busy_o),       32'd0);
      check("rst_done",   32'(bus.done_o),       32'd0);
      check("rst_error",  32'(bus.error_o),      32'd0);
      reset = 1'b0;

      // Basic two-word image
      stim = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h07};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      stim.push_back(8'h51);
`endif
      run_session(100);
      check("basic_w0", (wr_data.size() > 0) ? wr_data[0] : 32'hx, 32'h2002_0005);
      check("basic_a1", (wr_addr.size() > 1) ? wr_addr[1] : 32'hx, 32'h0040_0004);

      // Illegal headers
      stim = '{8'd0};
      run_session(100);
      stim = '{8'd33};
      run_session(100);
      stim.delete();
      stim.push_back(8'($urandom_range(255, 33)));
      run_session(60);

      // Random images with gaps and backpressure
      for (int k = 0; k < 6; k++) begin
         n = $urandom_range(1, 8);
         build(n, 1'b1);
         run_session($urandom_range(30, 100));
      end

      // Reset after six bytes of a four-word image
      build(4, 1'b1);
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      fed = 0;
      for (int b = 0; b < 100 && fed < 6; b++) begin
         bus.byte_valid_i = 1'b1;
         bus.byte_data_i = stim[fed];
         if (bus.byte_ready_o) fed++;
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_busy",   32'(bus.busy_o),       32'd0);
      check("midrst_cpurst", 32'(bus.cpu_reset_o),  32'd1);
      check("midrst_ready",  32'(bus.byte_ready_o), 32'd0);
      repeat (20) begin
         bus.byte_data_i = 8'($urandom);
         @(negedge clk);
      end
      bus.byte_valid_i = 1'b0;
      check("midrst_writes", 32'(wr_addr.size()), 32'd1);
      build(3, 1'b1);
      run_session(70);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      stim = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      run_session(100);
      stim = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
      run_session(100);
      build($urandom_range(1, 6), 1'b0);
      run_session(80);
`endif

      // Full depth, entered from DONE
      build(DEPTH, 1'b1);
      run_session(90);
      check("last_addr", (wr_addr.size() == DEPTH) ? wr_addr[DEPTH-1] : 32'hx, 32'h0040_007C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
